// File: rtl/led_blinker_array.sv
`default_nettype none
// ============================================================================
//  Module      : led_blinker_array
//  Description : Multi-channel LED blinker. Each channel runs a free-running
//                counter against a runtime-programmable terminal value and
//                drives one registered LED output plus a one-cycle tick pulse.
//                A single-cycle config port reprograms one channel at a time.
//  Ports       : clock      - system clock, rising edge
//                reset      - synchronous, active-high reset
//                enable     - global count enable (low freezes all channels)
//                cfg_we     - config write strobe
//                cfg_sel    - channel index for the write
//                cfg_period - new terminal value for the selected channel
//                cfg_mode   - new mode: 00 OFF, 01 ON, 10 TOGGLE, 11 PULSE
//                leds       - registered LED outputs, bit i = channel i
//                tick       - registered terminal pulse, bit i = channel i
//  Revision    : 1.0 - initial release
// ============================================================================
module led_blinker_array #(
    parameter int CHANNELS       = 4,
    parameter int CNT_WIDTH      = 26,
    parameter int SEL_WIDTH      = 2,
    parameter int DEFAULT_PERIOD = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 cfg_we,
    input  logic [SEL_WIDTH-1:0] cfg_sel,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic [1:0]           cfg_mode,
    output logic [CHANNELS-1:0]  leds,
    output logic [CHANNELS-1:0]  tick
);

    localparam logic [1:0] c_MODE_OFF    = 2'b00;
    localparam logic [1:0] c_MODE_ON     = 2'b01;
    localparam logic [1:0] c_MODE_TOGGLE = 2'b10;
    localparam logic [1:0] c_MODE_PULSE  = 2'b11;

    localparam logic [CNT_WIDTH-1:0] c_DEFAULT_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE        = CNT_WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        // Channel indices never reach CHANNELS, so any cfg_sel at or above
        // CHANNELS matches no channel and the write is dropped naturally.
        localparam logic [SEL_WIDTH-1:0] c_IDX = SEL_WIDTH'(i);

        logic [CNT_WIDTH-1:0] r_cnt_q,    w_cnt_d;
        logic [CNT_WIDTH-1:0] r_period_q, w_period_d;
        logic [1:0]           r_mode_q,   w_mode_d;
        logic                 r_state_q,  w_state_d;
        logic                 r_tick_q,   w_tick_d;
        logic                 r_led_q,    w_led_d;
        logic                 w_sel;

        assign w_sel = cfg_we && (cfg_sel == c_IDX);

        always_comb begin
            w_cnt_d    = r_cnt_q;
            w_period_d = r_period_q;
            w_mode_d   = r_mode_q;
            w_state_d  = r_state_q;
            w_tick_d   = 1'b0;

            if (w_sel) begin
                // A write beats a coincident terminal: counter and LED state
                // restart from zero and no tick is emitted this cycle.
                w_period_d = cfg_period;
                w_mode_d   = cfg_mode;
                w_cnt_d    = '0;
                w_state_d  = 1'b0;
            end else if (!enable) begin
                // Hold counter and LED state; tick stays low.
            end else if (r_cnt_q == r_period_q) begin
                // Compare for equality so the counter never passes the
                // programmed period, even when it is all ones.
                w_cnt_d   = '0;
                w_tick_d  = 1'b1;
                w_state_d = ~r_state_q;
            end else begin
                w_cnt_d = r_cnt_q + c_CNT_ONE;
            end

            // LED is derived from next-state values so it is registered
            // alongside tick and the mode change lands on the same edge.
            case (w_mode_d)
                c_MODE_OFF:    w_led_d = 1'b0;
                c_MODE_ON:     w_led_d = 1'b1;
                c_MODE_TOGGLE: w_led_d = w_state_d;
                c_MODE_PULSE:  w_led_d = w_tick_d;
                default:       w_led_d = 1'b0;
            endcase
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_cnt_q    <= '0;
                r_period_q <= c_DEFAULT_PERIOD;
                r_mode_q   <= c_MODE_OFF;
                r_state_q  <= 1'b0;
                r_tick_q   <= 1'b0;
                r_led_q    <= 1'b0;
            end else begin
                r_cnt_q    <= w_cnt_d;
                r_period_q <= w_period_d;
                r_mode_q   <= w_mode_d;
                r_state_q  <= w_state_d;
                r_tick_q   <= w_tick_d;
                r_led_q    <= w_led_d;
            end
        end

        assign leds[i] = r_led_q;
        assign tick[i] = r_tick_q;
    end

endmodule
`default_nettype wire

// File: doc/led_blinker_array.md
Name: led_blinker_array

Overview:
- Multi-channel, parametrised successor to the single-channel count / terminal-detect / LED-toggle chain.
- Each channel has its own free-running counter with a runtime-programmable terminal value and an output mode.
- Each channel produces a registered LED output and a one-cycle tick pulse.
- Sits between the board clock and the LED bank; a small config port lets a host or FSM reprogram any channel at runtime.

Parameters:
- CHANNELS, 4: number of independent channels (1..16).
- CNT_WIDTH, 26: width of each channel counter and period register.
- SEL_WIDTH, 2: width of cfg_sel; must satisfy 2**SEL_WIDTH >= CHANNELS.
- DEFAULT_PERIOD, 10: terminal value loaded into every channel at reset.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  global count enable; low freezes all channels.
- cfg_we  input  1  config write strobe, one cycle.
- cfg_sel  input  SEL_WIDTH  channel index for the write.
- cfg_period  input  CNT_WIDTH  new terminal value P for the selected channel.
- cfg_mode  input  2  new mode for the selected channel.
  - 00 OFF
  - 01 ON
  - 10 TOGGLE
  - 11 PULSE
- leds  output  CHANNELS  registered LED outputs; bit i belongs to channel i.
- tick  output  CHANNELS  registered one-cycle terminal pulse per channel.

Behaviour:
- Reset (synchronous, overrides everything else):
  - every cnt[i] = 0, period[i] = DEFAULT_PERIOD, mode[i] = OFF.
  - leds = 0, tick = 0.
- Per channel i, each rising edge, in priority order:
  1. reset.
  2. Config write: cfg_we=1 and cfg_sel==i.
     - period[i] <= cfg_period, mode[i] <= cfg_mode, cnt[i] <= 0.
     - tick[i] <= 0, led state[i] <= 0.
     - The write wins over a coincident terminal: no tick is produced that cycle.
  3. enable=0: cnt[i] and led state[i] hold; tick[i] <= 0.
  4. cnt[i]==period[i]:
     - cnt[i] <= 0, tick[i] <= 1, led state[i] toggles.
  5. Otherwise: cnt[i] <= cnt[i]+1, tick[i] <= 0.
- Period and timing:
  - tick[i] pulses once every P+1 enabled cycles.
  - The first tick is seen on the (P+1)th enabled edge after reset or a config write.
- Period 0:
  - tick[i] is high on every enabled cycle.
  - TOGGLE output then runs at half the clock rate.
- Counter width: the counter never exceeds period[i], so no wrap-around beyond the programmed period occurs. P = 2**CNT_WIDTH-1 is legal.
- cfg_sel >= CHANNELS: the write is ignored and no channel changes.
- leds[i] by mode (all registered, no combinational path from inputs):
  - OFF: 0.
  - ON: 1.
  - TOGGLE: led state[i], square wave with period 2(P+1) cycles.
  - PULSE: equals tick[i], one cycle high per terminal.
- Counting continues in every mode, so tick[i] is valid even in OFF and ON.
- Mode changes take effect on the edge after the write, together with the counter clear.
- Channels are fully independent. Only one channel can be written per cycle.
- Reset asserted mid-count returns the block to the reset values on the next edge, regardless of enable or cfg_we.

Test Plan:
- Reset, then hold enable=1 with no writes: ch0 sees tick[0]=1 on edges 11, 22, 33; leds=0 because mode is OFF.
- Write ch1 P=3, mode TOGGLE: leds[1] toggles every 4 cycles (period 8); tick[1] is high on cycles 4, 8, 12 after the write.
- Write ch2 P=0, mode PULSE: leds[2]=tick[2]=1 on every enabled cycle. Drop enable for 5 cycles: both read 0 and cnt holds. On re-enable, the pulses resume immediately.
- On ch3 (P=5, TOGGLE), issue a write exactly on the terminal cycle: no tick that cycle, leds[3]=0, and the next tick comes P_new+1 cycles later.
- Write with cfg_sel=3 and CHANNELS=3: no change to any channel's leds or tick spacing. Write mode ON: leds[i]=1 on the next edge while tick continues every P+1 cycles.
- Assert reset for 1 cycle mid-count with cfg_we=1 and enable=1: all outputs are 0 on the next edge and periods return to 10.
